// File: rtl/axi4_burst_ram.sv
// AXI4 slave RAM with FIXED/INCR/WRAP bursts; optional AXI4_BURST_RAM_RANGE_CHECK_EN flags out-of-range beats SLVERR.
// Read data appears RD_LATENCY+1 cycles after AR; one burst per channel, full-throughput R beats under r_ready.
module axi4_burst_ram #(
   parameter int MEM_BYTES  = 131072,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int RD_LATENCY = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [ID_WIDTH-1:0]       aw_id,
   input  logic [ADDR_WIDTH-1:0]     aw_addr,
   input  logic [7:0]                aw_len,
   input  logic [2:0]                aw_size,
   input  logic [1:0]                aw_burst,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [DATA_WIDTH-1:0]     w_data,
   input  logic [DATA_WIDTH/8-1:0]   w_strb,
   input  logic                      w_last,
   output logic                      b_valid,
   input  logic                      b_ready,
   output logic [ID_WIDTH-1:0]       b_id,
   output logic [1:0]                b_resp,
   input  logic                      ar_valid,
   output logic                      ar_ready,
   input  logic [ID_WIDTH-1:0]       ar_id,
   input  logic [ADDR_WIDTH-1:0]     ar_addr,
   input  logic [7:0]                ar_len,
   input  logic [2:0]                ar_size,
   input  logic [1:0]                ar_burst,
   output logic                      r_valid,
   input  logic                      r_ready,
   output logic [ID_WIDTH-1:0]       r_id,
   output logic [DATA_WIDTH-1:0]     r_data,
   output logic [1:0]                r_resp,
   output logic                      r_last
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int DEPTH  = MEM_BYTES / STRB_W;
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [2:0]            size,
      input logic [7:0]            len,
      input logic [1:0]            burst
   );
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] mask;
      step = ADDR_WIDTH'(1) << size;
      mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   return addr;
         2'b10:   return (addr & ~mask) | ((addr + step) & mask);
         default: return addr + step;
      endcase
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write channel state
   wr_state_t             wr_state_q;
   logic                  aw_ready_q;
   logic                  w_ready_q;
   logic                  b_valid_q;
   logic [ID_WIDTH-1:0]   b_id_q;
   logic [1:0]            b_resp_q;
   logic [ID_WIDTH-1:0]   wr_id_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [ADDR_WIDTH-1:0] wr_addr_d;
   logic [7:0]            wr_len_q;
   logic [2:0]            wr_size_q;
   logic [1:0]            wr_burst_q;
   logic [7:0]            wr_cnt_q;
   logic                  wr_err_q;
   logic                  wr_fire;
   logic                  wr_last_beat;
   logic                  wr_oob;
   logic                  wr_beat_err;
   logic [IDX_W-1:0]      wr_idx;

   // Read channel state
   rd_state_t             rd_state_q;
   logic                  ar_ready_q;
   logic                  r_valid_q;
   logic [ID_WIDTH-1:0]   r_id_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic [1:0]            r_resp_q;
   logic                  r_last_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [ADDR_WIDTH-1:0] rd_addr_d;
   logic [7:0]            rd_len_q;
   logic [2:0]            rd_size_q;
   logic [1:0]            rd_burst_q;
   logic [7:0]            rd_cnt_q;
   logic [3:0]            rd_wait_q;
   logic                  rd_oob;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;

`ifdef AXI4_BURST_RAM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
   assign wr_oob = (wr_addr_q >= MEM_LIMIT);
   assign rd_oob = (rd_addr_q >= MEM_LIMIT);
`else
   assign wr_oob = 1'b0;
   assign rd_oob = 1'b0;
`endif

   assign wr_fire      = w_valid && w_ready_q;
   assign wr_last_beat = (wr_cnt_q == wr_len_q);
   assign wr_beat_err  = (w_last != wr_last_beat) || wr_oob;
   assign wr_addr_d    = next_addr(wr_addr_q, wr_size_q, wr_len_q, wr_burst_q);
   assign wr_idx       = wr_addr_q[OFF_W +: IDX_W];

   assign rd_addr_d    = next_addr(rd_addr_q, rd_size_q, rd_len_q, rd_burst_q);
   assign rd_idx       = rd_addr_q[OFF_W +: IDX_W];
   assign rd_word      = mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= WR_IDLE;
         aw_ready_q <= 1'b1;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_id_q     <= '0;
         b_resp_q   <= 2'b00;
         wr_id_q    <= '0;
         wr_addr_q  <= '0;
         wr_len_q   <= '0;
         wr_size_q  <= '0;
         wr_burst_q <= '0;
         wr_cnt_q   <= '0;
         wr_err_q   <= 1'b0;
      end else begin
         case (wr_state_q)
            WR_IDLE: begin
               if (aw_valid && aw_ready_q) begin
                  wr_id_q    <= aw_id;
                  wr_addr_q  <= aw_addr;
                  wr_len_q   <= aw_len;
                  wr_size_q  <= aw_size;
                  wr_burst_q <= aw_burst;
                  wr_cnt_q   <= '0;
                  wr_err_q   <= 1'b0;
                  aw_ready_q <= 1'b0;
                  w_ready_q  <= 1'b1;
                  wr_state_q <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (wr_fire) begin
                  wr_addr_q <= wr_addr_d;
                  wr_cnt_q  <= wr_cnt_q + 8'd1;
                  wr_err_q  <= wr_err_q || wr_beat_err;
                  // Beat count, not w_last, terminates the burst.
                  if (wr_last_beat) begin
                     w_ready_q  <= 1'b0;
                     b_valid_q  <= 1'b1;
                     b_id_q     <= wr_id_q;
                     b_resp_q   <= (wr_err_q || wr_beat_err) ? 2'b10 : 2'b00;
                     wr_state_q <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (b_ready) begin
                  b_valid_q  <= 1'b0;
                  aw_ready_q <= 1'b1;
                  wr_state_q <= WR_IDLE;
               end
            end
            default: begin
               wr_state_q <= WR_IDLE;
               aw_ready_q <= 1'b1;
               w_ready_q  <= 1'b0;
               b_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   // Memory is deliberately outside reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_fire && !wr_oob) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) begin
               mem[wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= RD_IDLE;
         ar_ready_q <= 1'b1;
         r_valid_q  <= 1'b0;
         r_id_q     <= '0;
         r_data_q   <= '0;
         r_resp_q   <= 2'b00;
         r_last_q   <= 1'b0;
         rd_addr_q  <= '0;
         rd_len_q   <= '0;
         rd_size_q  <= '0;
         rd_burst_q <= '0;
         rd_cnt_q   <= '0;
         rd_wait_q  <= '0;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (ar_valid && ar_ready_q) begin
                  r_id_q     <= ar_id;
                  rd_addr_q  <= ar_addr;
                  rd_len_q   <= ar_len;
                  rd_size_q  <= ar_size;
                  rd_burst_q <= ar_burst;
                  rd_cnt_q   <= '0;
                  ar_ready_q <= 1'b0;
                  if (RD_LATENCY == 0) begin
                     rd_state_q <= RD_DATA;
                  end else begin
                     rd_wait_q  <= 4'(RD_LATENCY);
                     rd_state_q <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (rd_wait_q == 4'd1) begin
                  rd_state_q <= RD_DATA;
               end else begin
                  rd_wait_q <= rd_wait_q - 4'd1;
               end
            end
            RD_DATA: begin
               if (r_valid_q && r_ready && r_last_q) begin
                  r_valid_q  <= 1'b0;
                  r_last_q   <= 1'b0;
                  ar_ready_q <= 1'b1;
                  rd_state_q <= RD_IDLE;
               end else if (!r_valid_q || r_ready) begin
                  // Loading on the handshake edge keeps beats back-to-back.
                  r_valid_q <= 1'b1;
                  r_data_q  <= rd_oob ? '0 : rd_word;
                  r_resp_q  <= rd_oob ? 2'b10 : 2'b00;
                  r_last_q  <= (rd_cnt_q == rd_len_q);
                  rd_cnt_q  <= rd_cnt_q + 8'd1;
                  rd_addr_q <= rd_addr_d;
               end
            end
            default: begin
               rd_state_q <= RD_IDLE;
               ar_ready_q <= 1'b1;
               r_valid_q  <= 1'b0;
               r_last_q   <= 1'b0;
            end
         endcase
      end
   end

   assign aw_ready = aw_ready_q;
   assign w_ready  = w_ready_q;
   assign b_valid  = b_valid_q;
   assign b_id     = b_id_q;
   assign b_resp   = b_resp_q;
   assign ar_ready = ar_ready_q;
   assign r_valid  = r_valid_q;
   assign r_id     = r_id_q;
   assign r_data   = r_data_q;
   assign r_resp   = r_resp_q;
   assign r_last   = r_last_q;

endmodule

// File: tb/tb_axi4_burst_ram.sv
// Directed plus randomized bursts checked against a byte-array memory model of axi4_burst_ram.
module tb_axi4_burst_ram;

   localparam int DW  = 64;
   localparam int AW  = 32;
   localparam int IW  = 4;
   localparam int MB  = 4096;
   localparam int LAT = 2;
   localparam int SW  = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          aw_valid = 1'b0, aw_ready;
   logic [IW-1:0] aw_id = '0;
   logic [AW-1:0] aw_addr = '0;
   logic [7:0]    aw_len = '0;
   logic [2:0]    aw_size = '0;
   logic [1:0]    aw_burst = '0;
   logic          w_valid = 1'b0, w_ready;
   logic [DW-1:0] w_data = '0;
   logic [SW-1:0] w_strb = '0;
   logic          w_last = 1'b0;
   logic          b_valid, b_ready = 1'b0;
   logic [IW-1:0] b_id;
   logic [1:0]    b_resp;
   logic          ar_valid = 1'b0, ar_ready;
   logic [IW-1:0] ar_id = '0;
   logic [AW-1:0] ar_addr = '0;
   logic [7:0]    ar_len = '0;
   logic [2:0]    ar_size = '0;
   logic [1:0]    ar_burst = '0;
   logic          r_valid, r_ready = 1'b0;
   logic [IW-1:0] r_id;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic          r_last;

   always #5 clk = ~clk;

   axi4_burst_ram #(
      .MEM_BYTES(MB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RD_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
      .r_resp(r_resp), .r_last(r_last)
   );

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    mref [MB];
   logic [DW-1:0] wq_data [$];
   logic [SW-1:0] wq_strb [$];
   logic [DW-1:0] rx_data [$];
   longint        cur_addr;
   int            cur_size, cur_len, cur_burst, wbeat;
   logic          wr_err_exp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Byte address of beat i, straight from the burst-type arithmetic.
   function automatic longint beat_addr(input longint a, input int size, input int len,
                                        input int burst, input int i);
      longint step, span, base;
      step = longint'(1) << size;
      if (burst == 0) return a;
      if (burst == 2) begin
         span = step * (len + 1);
         base = a - (a % span);
         return base + ((a - base) + step * i) % span;
      end
      return a + step * i;
   endfunction

   function automatic logic is_oob(input longint a);
`ifdef AXI4_BURST_RAM_RANGE_CHECK_EN
      return a >= MB;
`else
      return (a < 0);
`endif
   endfunction

   function automatic int word_base(input longint a);
      longint m;
      m = a % MB;
      return int'(m - (m % SW));
   endfunction

   function automatic logic [63:0] ref_word(input longint a);
      logic [63:0] w;
      int          base;
      base = word_base(a);
      for (int b = 0; b < SW; b++) w[b*8 +: 8] = mref[base + b];
      return w;
   endfunction

   task automatic check_reset(input string pfx);
      chk({pfx, "_aw_ready"}, 64'(aw_ready), 64'd1);
      chk({pfx, "_ar_ready"}, 64'(ar_ready), 64'd1);
      chk({pfx, "_w_ready"},  64'(w_ready),  64'd0);
      chk({pfx, "_b_valid"},  64'(b_valid),  64'd0);
      chk({pfx, "_r_valid"},  64'(r_valid),  64'd0);
      chk({pfx, "_r_last"},   64'(r_last),   64'd0);
      chk({pfx, "_b_resp"},   64'(b_resp),   64'd0);
      chk({pfx, "_r_resp"},   64'(r_resp),   64'd0);
      chk({pfx, "_b_id"},     64'(b_id),     64'd0);
      chk({pfx, "_r_id"},     64'(r_id),     64'd0);
      chk({pfx, "_r_data"},   r_data,        64'd0);
   endtask

   task automatic do_aw(input logic [IW-1:0] id, input longint addr, input int len,
                        input int size, input int burst);
      int n;
      aw_id = id; aw_addr = addr[AW-1:0]; aw_len = 8'(len);
      aw_size = 3'(size); aw_burst = 2'(burst); aw_valid = 1'b1;
      n = 0;
      while (!aw_ready && n < 50) begin @(negedge clk); n++; end
      chk("aw_ready_wait", 64'(aw_ready), 64'd1);
      @(negedge clk);
      aw_valid = 1'b0;
      cur_addr = addr; cur_len = len; cur_size = size; cur_burst = burst;
      wbeat = 0; wr_err_exp = 1'b0;
   endtask

   task automatic do_w(input int nbeats, input bit bad_last);
      longint a;
      int     base;
      for (int i = 0; i < nbeats; i++) begin
         w_valid = 1'b0;
         repeat ($urandom_range(0, 1)) @(negedge clk);
         w_valid = 1'b1;
         w_data  = wq_data.pop_front();
         w_strb  = wq_strb.pop_front();
         w_last  = (wbeat == cur_len) ^ (bad_last && wbeat == 0);
         chk("w_ready_in_burst", 64'(w_ready), 64'd1);
         a = beat_addr(cur_addr, cur_size, cur_len, cur_burst, wbeat);
         if (is_oob(a)) wr_err_exp = 1'b1;
         else begin
            base = word_base(a);
            for (int b = 0; b < SW; b++) if (w_strb[b]) mref[base + b] = w_data[b*8 +: 8];
         end
         if (w_last != (wbeat == cur_len)) wr_err_exp = 1'b1;
         @(negedge clk);
         wbeat++;
      end
      w_valid = 1'b0;
      w_last  = 1'b0;
   endtask

   task automatic do_b(input logic [IW-1:0] exp_id);
      chk("b_valid_next_cycle", 64'(b_valid), 64'd1);
      chk("w_ready_after_last", 64'(w_ready), 64'd0);
      chk("b_id", 64'(b_id), 64'(exp_id));
      chk("b_resp", 64'(b_resp), wr_err_exp ? 64'd2 : 64'd0);
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         chk("b_valid_hold", 64'(b_valid), 64'd1);
         chk("b_id_hold", 64'(b_id), 64'(exp_id));
      end
      b_ready = 1'b1;
      @(negedge clk);
      b_ready = 1'b0;
      chk("b_valid_drop", 64'(b_valid), 64'd0);
      chk("aw_ready_after_b", 64'(aw_ready), 64'd1);
   endtask

   task automatic do_read(input logic [IW-1:0] id, input longint addr, input int len,
                          input int size, input int burst, input int stall_beat);
      int            n, beat, cyc, stall;
      bit            held, prev_hs;
      logic [DW-1:0] h_data;
      logic [1:0]    h_resp;
      logic          h_last;
      longint        a;
      ar_id = id; ar_addr = addr[AW-1:0]; ar_len = 8'(len);
      ar_size = 3'(size); ar_burst = 2'(burst); ar_valid = 1'b1;
      n = 0;
      while (!ar_ready && n < 50) begin @(negedge clk); n++; end
      chk("ar_ready_wait", 64'(ar_ready), 64'd1);
      @(negedge clk);
      ar_valid = 1'b0;
      n = 0;
      while (!r_valid && n < 40) begin @(negedge clk); n++; end
      chk("r_first_latency", 64'(n), 64'(LAT + 1));
      rx_data.delete();
      beat = 0; cyc = 0; stall = 0; held = 0; prev_hs = 0;
      h_data = '0; h_resp = '0; h_last = 1'b0;
      while (beat <= len && cyc < 2000) begin
         if (beat == stall_beat && stall < 5) begin r_ready = 1'b0; stall++; end
         else r_ready = ($urandom_range(0, 3) != 0);
         if (prev_hs) chk("r_no_bubble", 64'(r_valid), 64'd1);
         if (held) begin
            chk("stall_r_valid", 64'(r_valid), 64'd1);
            chk("stall_r_data", r_data, h_data);
            chk("stall_r_resp", 64'(r_resp), 64'(h_resp));
            chk("stall_r_last", 64'(r_last), 64'(h_last));
         end
         held = 0; prev_hs = 0;
         if (r_valid && r_ready) begin
            a = beat_addr(addr, size, len, burst, beat);
            chk("r_data", r_data, is_oob(a) ? 64'd0 : ref_word(a));
            chk("r_resp", 64'(r_resp), is_oob(a) ? 64'd2 : 64'd0);
            chk("r_last", 64'(r_last), 64'(beat == len));
            chk("r_id", 64'(r_id), 64'(id));
            rx_data.push_back(r_data);
            beat++;
            prev_hs = (beat <= len);
         end else if (r_valid) begin
            held = 1; h_data = r_data; h_resp = r_resp; h_last = r_last;
         end
         @(negedge clk);
         cyc++;
      end
      r_ready = 1'b0;
      chk("r_beat_count", 64'(beat), 64'(len + 1));
      chk("r_valid_after_last", 64'(r_valid), 64'd0);
      chk("ar_ready_after_last", 64'(ar_ready), 64'd1);
   endtask

   task automatic chk_rx(input string tag, input int i, input logic [63:0] exp);
      chk(tag, (i < rx_data.size()) ? rx_data[i] : 64'hDEAD_DEAD_DEAD_DEAD, exp);
   endtask

   task automatic push_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
      wq_data.push_back(d);
      wq_strb.push_back(s);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int burst, size, len;
      longint addr;

      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Fill the whole memory with random data using two 256-beat INCR bursts.
      for (int h = 0; h < 2; h++) begin
         for (int i = 0; i < 256; i++) push_beat({$urandom, $urandom}, 8'hFF);
         do_aw(4'(h + 1), longint'(h * 2048), 255, 3, 1);
         do_w(256, 0);
         do_b(4'(h + 1));
      end

      // INCR write/read, id 5 at 0x100.
      for (int i = 1; i <= 4; i++) push_beat(64'(i), 8'hFF);
      do_aw(4'd5, 64'h100, 3, 3, 1);
      do_w(4, 0);
      do_b(4'd5);
      do_read(4'd5, 64'h100, 3, 3, 1, -1);
      for (int i = 0; i < 4; i++) chk_rx("incr_readback", i, 64'(i + 1));

      // WRAP write starting mid-window.
      push_beat(64'hA, 8'hFF); push_beat(64'hB, 8'hFF);
      push_beat(64'hC, 8'hFF); push_beat(64'hD, 8'hFF);
      do_aw(4'd2, 64'h118, 3, 3, 2);
      do_w(4, 0);
      do_b(4'd2);
      do_read(4'd3, 64'h100, 3, 3, 1, -1);
      chk_rx("wrap_0x100", 0, 64'hB);
      chk_rx("wrap_0x108", 1, 64'hC);
      chk_rx("wrap_0x110", 2, 64'hD);
      chk_rx("wrap_0x118", 3, 64'hA);

      // Partial strobe merge.
      push_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      do_aw(4'd4, 64'h200, 0, 3, 1);
      do_w(1, 0);
      do_b(4'd4);
      push_beat(64'h1111_1111_1111_1111, 8'h0F);
      do_aw(4'd4, 64'h200, 0, 3, 1);
      do_w(1, 0);
      do_b(4'd4);
      do_read(4'd4, 64'h200, 0, 3, 1, -1);
      chk_rx("strb_merge", 0, 64'hAAAA_AAAA_1111_1111);

      // Five-cycle r_ready stall during the second beat.
      do_read(4'd7, 64'h100, 3, 3, 1, 1);
      chk_rx("stall_beat0", 0, 64'hB);
      chk_rx("stall_beat1", 1, 64'hC);
      chk_rx("stall_beat2", 2, 64'hD);
      chk_rx("stall_beat3", 3, 64'hA);

      // Early w_last gives SLVERR but the burst still runs its full length.
      push_beat({$urandom, $urandom}, 8'hFF); push_beat({$urandom, $urandom}, 8'hFF);
      do_aw(4'd6, 64'h400, 1, 3, 1);
      do_w(2, 1);
      do_b(4'd6);

      // Address just past the end of memory.
      do_read(4'd9, 64'h1000, 0, 3, 1, -1);
`ifdef AXI4_BURST_RAM_RANGE_CHECK_EN
      chk_rx("oob_read_zero", 0, 64'd0);
`else
      chk_rx("alias_word0", 0, ref_word(0));
`endif

      // Reset in the middle of a write burst.
      push_beat(64'h1234_5678_9ABC_DEF0, 8'hFF);
      do_aw(4'd3, 64'h300, 3, 3, 1);
      do_w(1, 0);
      rst_n = 1'b0;
      #1;
      check_reset("midburst_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_b_after_reset", 64'(b_valid), 64'd0);
         chk("aw_ready_after_reset", 64'(aw_ready), 64'd1);
      end
      for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, 8'hFF);
      do_aw(4'd8, 64'h300, 3, 3, 1);
      do_w(4, 0);
      do_b(4'd8);
      do_read(4'd8, 64'h300, 3, 3, 1, -1);

      // Random bursts of every type and size.
      for (int t = 0; t < 14; t++) begin
         burst = int'($urandom_range(0, 3));
         size  = int'($urandom_range(0, 3));
         len   = (burst == 2) ? ((2 << $urandom_range(0, 3)) - 1) : int'($urandom_range(0, 15));
         addr  = longint'($urandom_range(32'h400, 32'hDFF)) & ~((longint'(1) << size) - 1);
         for (int i = 0; i <= len; i++) push_beat({$urandom, $urandom}, 8'($urandom));
         do_aw(4'(t), addr, len, size, burst);
         do_w(len + 1, 0);
         do_b(4'(t));
         do_read(4'(t + 1), addr, len, size, burst, int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4_burst_ram.md
AXI4_BURST_RAM -- requirements
Module: axi4_burst_ram

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 131072: memory size in bytes, power of two.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: data width, 32/64/128/256; STRB_W = DATA_WIDTH/8.
REQ-004 SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-005 SHALL have parameter RD_LATENCY, default 0: extra cycles, 0..15, between AR handshake and first R beat.
REQ-006 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have write-address ports: aw_valid in 1; aw_ready out 1; aw_id in ID_WIDTH; aw_addr in ADDR_WIDTH; aw_len in 8; aw_size in 3; aw_burst in 2.
REQ-009 SHALL have write-data ports: w_valid in 1; w_ready out 1; w_data in DATA_WIDTH; w_strb in STRB_W; w_last in 1.
REQ-010 SHALL have write-response ports: b_valid out 1; b_ready in 1; b_id out ID_WIDTH; b_resp out 2.
REQ-011 SHALL have read-address ports: ar_valid in 1; ar_ready out 1; ar_id in ID_WIDTH; ar_addr in ADDR_WIDTH; ar_len in 8; ar_size in 3; ar_burst in 2.
REQ-012 SHALL have read-data ports: r_valid out 1; r_ready in 1; r_id out ID_WIDTH; r_data out DATA_WIDTH; r_resp out 2; r_last out 1.

Function
REQ-013 SHALL run independent write FSM (WR_IDLE, WR_DATA, WR_RESP) and read FSM (RD_IDLE, RD_WAIT, RD_DATA); one burst per channel in flight.
REQ-014 SHALL assert aw_ready only in WR_IDLE and ar_ready only in RD_IDLE; handshake latches id, addr, len, size, burst; all later address steps use latched size, never live port.
REQ-015 SHALL compute word index as addr >> log2(STRB_W); without RANGE_CHECK, index taken modulo MEM_BYTES/STRB_W.
REQ-016 SHALL advance address per beat: FIXED (00) unchanged; INCR (01) +2^size; WRAP (10) +2^size wrapped within boundary aligned to (len+1)*2^size; reserved (11) treated as INCR.
REQ-017 SHALL assert w_ready throughout WR_DATA; each w handshake writes only byte lanes with w_strb set.
REQ-018 SHALL end write burst on beat number aw_len (count from 0), go WR_RESP and assert b_valid next cycle with latched b_id; b_resp OKAY (00), or SLVERR (10) if w_last disagrees with beat count anywhere in burst.
REQ-019 SHALL hold b_valid/b_id/b_resp until b_ready; WR_IDLE, aw_ready=1 cycle after B handshake.
REQ-020 SHALL, on AR handshake, enter RD_WAIT for RD_LATENCY cycles (skipped when 0); first r_valid rises RD_LATENCY+1 cycles after handshake.
REQ-021 SHALL keep r_data/r_id/r_resp/r_last stable while r_valid=1 and r_ready=0; next beat loads in same cycle as handshake (full throughput, no bubble).
REQ-022 SHALL assert r_last only on beat ar_len; after its handshake r_valid drops, RD_IDLE, ar_ready=1 next cycle.
REQ-023 SHALL return whole memory word on narrow (size < log2(STRB_W)) reads; lane selection left to master.
REQ-024 SHALL give read-before-write ordering: read beat loaded in same cycle as write to same word returns pre-write data.

Reset
REQ-025 SHALL on rst_n low force: aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0, b_resp=00, r_resp=00, b_id=0, r_id=0, r_data=0, both FSMs idle.
REQ-026 SHALL abandon any in-progress burst on reset with no further B or R beats; memory contents not reset.

Configuration
REQ-027 SHALL honour macro AXI4_BURST_RAM_RANGE_CHECK_EN: when defined, any beat with byte address >= MEM_BYTES suppresses write and yields SLVERR (10) (B for write burst, per beat on R with r_data=0); when undefined, addresses alias modulo MEM_BYTES and responses always OKAY except REQ-018 w_last mismatch.

Verification (DATA_WIDTH=64, MEM_BYTES=4096, RD_LATENCY=2)
REQ-028 SHALL cover INCR write id=5 addr 0x100 len=3 size=3 data 1,2,3,4 strb FF -> b_id=5 b_resp=00; INCR read same -> 1,2,3,4, r_last on 4th, first r_valid 3 cycles after AR.
REQ-029 SHALL cover WRAP write len=3 size=3 addr 0x118 data A,B,C,D -> words 0x118=A, 0x100=B, 0x108=C, 0x110=D on readback.
REQ-030 SHALL cover word 0x200 preset 0xAAAAAAAAAAAAAAAA, write 0x1111111111111111 strb 0x0F -> reads 0xAAAAAAAA11111111.
REQ-031 SHALL cover r_ready low 5 cycles during beat 2 of 4-beat read -> r_data stable, all 4 beats delivered in order exactly once.
REQ-032 SHALL cover read addr 0x1000 len=0: with macro -> r_resp=10, r_data=0; without -> data of word 0x000, r_resp=00.
REQ-033 SHALL cover rst_n pulsed low after beat 1 of 4-beat write -> b_valid stays 0, aw_ready=1 after release, new burst completes OKAY.
